// File: rtl/gnr_node_mc.sv
// Multi-channel Boolean GRN node: CHANNELS independent state copies of one gene,
// each with its own update divider and settle (stability) tracking.
module gnr_node_mc #(
  parameter int CHANNELS = 2,
  parameter int PERIOD_W = 2,
  parameter int STABLE_N = 4,
  parameter int STABLE_W = $clog2(STABLE_N + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         reset_nos,
  input  logic [CHANNELS-1:0]          start,
  input  logic [CHANNELS-1:0]          init_state,
  input  logic [CHANNELS*PERIOD_W-1:0] period,
  input  logic [CHANNELS-1:0]          next_e,
  output logic [CHANNELS-1:0]          s,
  output logic [CHANNELS-1:0]          changed,
  output logic [CHANNELS-1:0]          upd,
  output logic [CHANNELS-1:0]          stable,
  output logic                         all_stable
);

  localparam logic [STABLE_W-1:0] SMAX = STABLE_W'(STABLE_N);

  logic [PERIOD_W-1:0] r_cnt  [CHANNELS];
  logic [STABLE_W-1:0] r_scnt [CHANNELS];
  logic [CHANNELS-1:0] r_s;
  logic [CHANNELS-1:0] r_changed;
  logic [CHANNELS-1:0] r_upd;
  logic [CHANNELS-1:0] r_stable;
  logic                r_all_stable;

  logic [CHANNELS-1:0] w_fire;
  logic [CHANNELS-1:0] w_stable_nxt;

  always_comb begin
    w_fire       = '0;
    w_stable_nxt = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_fire[i]       = start[i] && (r_cnt[i] == '0);
      // stable tracks the counter one cycle late; reset_nos clears it outright
      w_stable_nxt[i] = !reset_nos && (r_scnt[i] == SMAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s          <= '0;
      r_changed    <= '0;
      r_upd        <= '0;
      r_stable     <= '0;
      r_all_stable <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_cnt[i]  <= '0;
        r_scnt[i] <= '0;
      end
    end else if (reset_nos) begin
      r_s          <= init_state;
      r_changed    <= '0;
      r_upd        <= '0;
      r_stable     <= '0;
      r_all_stable <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_cnt[i]  <= '0;
        r_scnt[i] <= '0;
      end
    end else begin
      r_stable     <= w_stable_nxt;
      r_all_stable <= &w_stable_nxt;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_upd[i]     <= w_fire[i];
        r_changed[i] <= w_fire[i] && (next_e[i] != r_s[i]);
        if (start[i]) begin
          if (r_cnt[i] == '0)
            r_cnt[i] <= period[i*PERIOD_W +: PERIOD_W];
          else
            r_cnt[i] <= r_cnt[i] - PERIOD_W'(1);
        end
        if (w_fire[i]) begin
          r_s[i] <= next_e[i];
          if (next_e[i] != r_s[i])
            r_scnt[i] <= '0;
          else if (r_scnt[i] != SMAX)
            r_scnt[i] <= r_scnt[i] + STABLE_W'(1);
        end
      end
    end
  end

  assign s          = r_s;
  assign changed    = r_changed;
  assign upd        = r_upd;
  assign stable     = r_stable;
  assign all_stable = r_all_stable;

endmodule

// File: tb/tb_gnr_node_mc.sv
// Directed bench for gnr_node_mc: reset, divider, period reload, stability and priority.
module tb_gnr_node_mc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       reset_nos = 1'b0;
  logic [1:0] start = '0;
  logic [1:0] init_state = '0;
  logic [3:0] period = '0;
  logic [1:0] next_e = '0;
  logic [1:0] s, changed, upd, stable;
  logic       all_stable;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] nv, eu, es;

  gnr_node_mc #(.CHANNELS(2), .PERIOD_W(2), .STABLE_N(4)) dut (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .start(start),
    .init_state(init_state), .period(period), .next_e(next_e),
    .s(s), .changed(changed), .upd(upd), .stable(stable), .all_stable(all_stable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_nos();
    reset_nos = 1'b1;
    step();
    reset_nos = 1'b0;
  endtask

  initial begin
    // power-on reset
    #3;
    chk("por_s", 32'(s), 0);
    chk("por_upd", 32'(upd), 0);
    chk("por_all", 32'(all_stable), 0);
    rst = 1'b0;

    // async reset mid-run with nonzero dividers
    period = 4'b1010; init_state = 2'b11;
    do_nos();
    chk("nos_s", 32'(s), 3);
    start = 2'b11; next_e = 2'b11;
    step();
    chk("run_upd", 32'(upd), 3);
    start = 2'b00;
    #2 rst = 1'b1;
    #1;
    chk("arst_s", 32'(s), 0);
    chk("arst_upd", 32'(upd), 0);
    chk("arst_chg", 32'(changed), 0);
    chk("arst_stb", 32'(stable), 0);
    chk("arst_all", 32'(all_stable), 0);
    rst = 1'b0;
    start = 2'b01; next_e = 2'b01;
    step();
    chk("post_rst_s", 32'(s), 1);
    chk("post_rst_upd", 32'(upd), 1);
    start = 2'b00;

    // divider period_0=1: update on starts 1,3,5
    period = 4'b0001; init_state = 2'b00;
    do_nos();
    nv = 5'b00101; eu = 5'b10101; es = 5'b01111;
    start = 2'b01;
    for (int k = 0; k < 5; k++) begin
      next_e = {1'b0, nv[k]};
      step();
      chk($sformatf("div1_upd%0d", k), 32'(upd[0]), 32'(eu[k]));
      chk($sformatf("div1_s%0d", k), 32'(s[0]), 32'(es[k]));
    end
    start = 2'b00;

    // period_0=0: update every start
    period = 4'b0000;
    do_nos();
    start = 2'b01;
    for (int k = 0; k < 3; k++) begin
      next_e = {1'b0, (k != 1)};
      step();
      chk($sformatf("div0_upd%0d", k), 32'(upd[0]), 1);
      chk($sformatf("div0_s%0d", k), 32'(s[0]), 32'(k != 1));
      chk($sformatf("div0_chg%0d", k), 32'(changed[0]), 1);
    end
    start = 2'b00;

    // period changed mid-count only takes effect on reload
    period = 4'b0011;
    do_nos();
    start = 2'b01; next_e = 2'b01;
    step();
    chk("mid_upd0", 32'(upd[0]), 1);
    period = 4'b0000; next_e = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mid_skip%0d", k), 32'(upd[0]), 0);
      chk($sformatf("mid_hold%0d", k), 32'(s[0]), 1);
    end
    step();
    chk("mid_upd4", 32'(upd[0]), 1);
    chk("mid_s4", 32'(s[0]), 0);
    next_e = 2'b01;
    step();
    chk("mid_upd5", 32'(upd[0]), 1);
    chk("mid_s5", 32'(s[0]), 1);
    start = 2'b00;

    // stability on channel 1
    period = 4'b0000; init_state = 2'b00;
    do_nos();
    start = 2'b10; next_e = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 4) chk("stb_pre", 32'(stable[1]), 0);
      if (k == 5) chk("stb_rise", 32'(stable[1]), 1);
    end
    next_e = 2'b10;
    step();
    chk("stb_chg", 32'(changed[1]), 1);
    chk("stb_hold", 32'(stable[1]), 1);
    step();
    chk("stb_drop", 32'(stable[1]), 0);
    chk("stb_chg_clr", 32'(changed[1]), 0);
    for (int k = 0; k < 4; k++) step();
    chk("stb_rerise", 32'(stable[1]), 1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("stb_sat%0d", k), 32'(stable[1]), 1);
    end
    next_e = 2'b00;
    step();
    step();
    chk("stb_drop2", 32'(stable[1]), 0);
    start = 2'b00;

    // all_stable rises only with the later channel
    do_nos();
    next_e = 2'b00;
    for (int k = 1; k <= 7; k++) begin
      start = {(k >= 3), 1'b1};
      step();
      if (k == 5 || k == 6) begin
        chk($sformatf("all_stb%0d", k), 32'(stable), 1);
        chk($sformatf("all_flag%0d", k), 32'(all_stable), 0);
      end
      if (k == 7) begin
        chk("all_stb7", 32'(stable), 3);
        chk("all_flag7", 32'(all_stable), 1);
      end
    end
    init_state = 2'b10;
    reset_nos = 1'b1;
    step();
    reset_nos = 1'b0;
    chk("renos_s", 32'(s), 2);
    chk("renos_stb", 32'(stable), 0);
    chk("renos_all", 32'(all_stable), 0);
    chk("renos_upd", 32'(upd), 0);

    // reset_nos beats start and clears a loaded divider
    period = 4'b0011; start = 2'b01; next_e = 2'b01;
    step();
    chk("pri_load", 32'(s), 3);
    reset_nos = 1'b1; start = 2'b11;
    step();
    reset_nos = 1'b0;
    chk("pri_s", 32'(s), 2);
    chk("pri_upd", 32'(upd), 0);
    start = 2'b01; next_e = 2'b01;
    step();
    chk("pri_cnt0_upd", 32'(upd), 1);
    chk("pri_cnt0_s", 32'(s), 3);
    start = 2'b00;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
